// File: rtl/wb_pkg.sv
// Shared constants for the writeback unit: opcodes, load funct3 codes, FSM states
// and the writeback-source decoder.
package wb_pkg;

    localparam logic [4:0] OPC_LOAD      = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
    localparam logic [4:0] OPC_AUIPC     = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
    localparam logic [4:0] OPC_STORE     = 5'b01000;
    localparam logic [4:0] OPC_OP        = 5'b01100;
    localparam logic [4:0] OPC_LUI       = 5'b01101;
    localparam logic [4:0] OPC_OP_32     = 5'b01110;
    localparam logic [4:0] OPC_BRANCH    = 5'b11000;
    localparam logic [4:0] OPC_JALR      = 5'b11001;
    localparam logic [4:0] OPC_JAL       = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_WAIT_LD = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_ALU  = 2'b01,
        SRC_LOAD = 2'b10,
        SRC_CSR  = 2'b11
    } src_e;

    // Stores, branches, ecall-class syscalls and malformed encodings never write rd.
    function automatic src_e wb_src(input logic [6:0] opcode, input logic [2:0] funct3);
        src_e src;
        src = SRC_NONE;
        if (opcode[1:0] == 2'b11) begin
            case (opcode[6:2])
                OPC_OP, OPC_OP_32, OPC_OP_IMM, OPC_OP_IMM_32,
                OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: src = SRC_ALU;
                OPC_LOAD:                              src = SRC_LOAD;
                OPC_SYSTEM: src = (funct3 != 3'b000) ? SRC_CSR : SRC_NONE;
                default:                               src = SRC_NONE;
            endcase
        end else begin
            src = SRC_NONE;
        end
        return src;
    endfunction

endpackage

// File: rtl/wb_load_fmt.sv
// Combinational load formatter: selects the addressed bytes of the raw aligned
// word and sign- or zero-extends them to XLEN.
module wb_load_fmt
    import wb_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] raw,
    input  logic [2:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    localparam int OFFW = (XLEN == 64) ? 3 : 2;

    logic [OFFW-1:0] off_s;
    logic [XLEN-1:0] shifted_s;
    logic [XLEN-1:0] mask_s;
    logic            sign_s;

    assign off_s     = offset[OFFW-1:0];
    assign shifted_s = raw >> {off_s, 3'b000};

    // Keep the low bytes of the access, then fill the upper bits with the sign if needed.
    always_comb begin
        mask_s = '1;
        sign_s = 1'b0;
        case (funct3)
            F3_LB:  begin mask_s = XLEN'(64'h0000_0000_0000_00FF); sign_s = shifted_s[7];  end
            F3_LH:  begin mask_s = XLEN'(64'h0000_0000_0000_FFFF); sign_s = shifted_s[15]; end
            F3_LW:  begin mask_s = XLEN'(64'h0000_0000_FFFF_FFFF); sign_s = shifted_s[31]; end
            F3_LD:  begin mask_s = '1;                              sign_s = 1'b0;          end
            F3_LBU: begin mask_s = XLEN'(64'h0000_0000_0000_00FF); sign_s = 1'b0;          end
            F3_LHU: begin mask_s = XLEN'(64'h0000_0000_0000_FFFF); sign_s = 1'b0;          end
            F3_LWU: begin mask_s = XLEN'(64'h0000_0000_FFFF_FFFF); sign_s = 1'b0;          end
            default: begin mask_s = '1;                             sign_s = 1'b0;          end
        endcase
        data = (shifted_s & mask_s) | (sign_s ? ~mask_s : '0);
    end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: registers MEM results into the register file and waits for
// late load responses. Optional commit trace is built when WB_TRACE_EN is defined.
module wb_unit
    import wb_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [ILEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_alures,
    input  logic [XLEN-1:0] in_csrdata,
    input  logic            ld_rsp_valid,
    input  logic [XLEN-1:0] ld_rsp_data,
    output logic            rd_wen,
    output logic [4:0]      rd_idx,
    output logic [XLEN-1:0] rd_data,
    output logic            ld_rsp_err
`ifdef WB_TRACE_EN
    ,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
    output logic [ILEN-1:0] commit_instr,
    output logic [63:0]     instret
`endif
);

    state_e          state_r, next_state_s;
    logic [ILEN-1:0] pend_instr_r;
    logic [2:0]      pend_off_r;
    logic            rd_wen_r;
    logic [4:0]      rd_idx_r;
    logic [XLEN-1:0] rd_data_r;
    logic            err_r;

    src_e            src_s;
    logic            idle_s;
    logic [2:0]      fmt_off_s;
    logic [2:0]      fmt_f3_s;
    logic [XLEN-1:0] fmt_data_s;
    logic            latch_s, complete_s, wen_s, err_set_s;
    logic [4:0]      idx_s;
    logic [XLEN-1:0] data_s;
    logic            unused_s;

    assign idle_s    = (state_r == ST_IDLE);
    assign src_s     = wb_src(in_instr[6:0], in_instr[14:12]);
    assign fmt_off_s = idle_s ? in_alures[2:0] : pend_off_r;
    assign fmt_f3_s  = idle_s ? in_instr[14:12] : pend_instr_r[14:12];
    assign unused_s  = ^{in_pc, in_instr[ILEN-1:15], pend_instr_r[ILEN-1:15], pend_instr_r[6:0]};

    wb_load_fmt #(.XLEN(XLEN)) u_fmt (
        .raw    (ld_rsp_data),
        .offset (fmt_off_s),
        .funct3 (fmt_f3_s),
        .data   (fmt_data_s)
    );

    // Next state and writeback selection; a pending load only ever holds a load, so no re-decode.
    always_comb begin
        next_state_s = state_r;
        latch_s      = 1'b0;
        complete_s   = 1'b0;
        wen_s        = 1'b0;
        err_set_s    = 1'b0;
        idx_s        = in_instr[11:7];
        data_s       = in_alures;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && (src_s == SRC_LOAD) && !ld_rsp_valid) begin
                    next_state_s = ST_WAIT_LD;
                    latch_s      = 1'b1;
                end else if (in_valid) begin
                    complete_s = 1'b1;
                    wen_s      = (src_s != SRC_NONE) && (in_instr[11:7] != 5'd0);
                end else begin
                    complete_s = 1'b0;
                end
                err_set_s = ld_rsp_valid && !(in_valid && (src_s == SRC_LOAD));
                case (src_s)
                    SRC_LOAD: data_s = fmt_data_s;
                    SRC_CSR:  data_s = in_csrdata;
                    default:  data_s = in_alures;
                endcase
            end
            ST_WAIT_LD: begin
                idx_s  = pend_instr_r[11:7];
                data_s = fmt_data_s;
                if (ld_rsp_valid) begin
                    next_state_s = ST_IDLE;
                    complete_s   = 1'b1;
                    wen_s        = (pend_instr_r[11:7] != 5'd0);
                end else begin
                    next_state_s = ST_WAIT_LD;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State, pending-load context and register-file write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            pend_instr_r <= '0;
            pend_off_r   <= 3'd0;
            rd_wen_r     <= 1'b0;
            rd_idx_r     <= 5'd0;
            rd_data_r    <= '0;
            err_r        <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            rd_wen_r <= wen_s;
            if (latch_s) begin
                pend_instr_r <= in_instr;
                pend_off_r   <= in_alures[2:0];
            end
            if (complete_s) begin
                rd_idx_r  <= idx_s;
                rd_data_r <= data_s;
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign in_ready   = idle_s;
    assign rd_wen     = rd_wen_r;
    assign rd_idx     = rd_idx_r;
    assign rd_data    = rd_data_r;
    assign ld_rsp_err = err_r;

`ifdef WB_TRACE_EN
    logic [XLEN-1:0] pend_pc_r;
    logic            commit_valid_r;
    logic [XLEN-1:0] commit_pc_r;
    logic [ILEN-1:0] commit_instr_r;
    logic [63:0]     instret_r;

    // Commit trace: every completed instruction, including ones that write nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_pc_r      <= '0;
            commit_valid_r <= 1'b0;
            commit_pc_r    <= '0;
            commit_instr_r <= '0;
            instret_r      <= 64'd0;
        end else begin
            commit_valid_r <= complete_s;
            if (latch_s) begin
                pend_pc_r <= in_pc;
            end
            if (complete_s) begin
                commit_pc_r    <= idle_s ? in_pc : pend_pc_r;
                commit_instr_r <= idle_s ? in_instr : pend_instr_r;
                instret_r      <= instret_r + 64'd1;
            end
        end
    end

    assign commit_valid = commit_valid_r;
    assign commit_pc    = commit_pc_r;
    assign commit_instr = commit_instr_r;
    assign instret      = instret_r;
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Scoreboard bench for wb_unit: stimulus pushes expected writebacks, a monitor
// pops and compares on every rd_wen pulse. Trace checks follow WB_TRACE_EN.
module tb_wb_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic [63:0] in_alures;
    logic [63:0] in_csrdata;
    logic        ld_rsp_valid;
    logic [63:0] ld_rsp_data;
    logic        rd_wen;
    logic [4:0]  rd_idx;
    logic [63:0] rd_data;
    logic        ld_rsp_err;
`ifdef WB_TRACE_EN
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic [31:0] commit_instr;
    logic [63:0] instret;
`endif

    wb_unit #(.XLEN(64), .ILEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .in_alures    (in_alures),
        .in_csrdata   (in_csrdata),
        .ld_rsp_valid (ld_rsp_valid),
        .ld_rsp_data  (ld_rsp_data),
        .rd_wen       (rd_wen),
        .rd_idx       (rd_idx),
        .rd_data      (rd_data),
        .ld_rsp_err   (ld_rsp_err)
`ifdef WB_TRACE_EN
        ,
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_instr (commit_instr),
        .instret      (instret)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  idx;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ncommit = 0;
    logic [63:0] pc_ctr = 64'h8000_0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rd_wen pulse must match the oldest expectation, at its cycle.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rd_wen === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb: got rd_wen=1 rd_idx=%0d, expected no writeback", rd_idx);
            end else begin
                e = q.pop_front();
                chk("wb_idx", {59'd0, rd_idx}, {59'd0, e.idx});
                chk("wb_data", rd_data, e.data);
                chk("wb_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
        return {7'h00, 5'd2, 5'd1, f3, rd, op};
    endfunction

    task automatic issue(input logic [31:0] ins, input logic [63:0] alu, input logic [63:0] csr,
                         input logic rv, input logic [63:0] rdata,
                         input logic ewen, input logic [63:0] edata, input logic done);
        @(negedge clk);
        in_valid     = 1'b1;
        in_instr     = ins;
        in_alures    = alu;
        in_csrdata   = csr;
        in_pc        = pc_ctr;
        ld_rsp_valid = rv;
        ld_rsp_data  = rdata;
        pc_ctr       = pc_ctr + 64'd4;
        if (ewen) q.push_back('{ins[11:7], edata, cyc + 1});
        if (done) ncommit++;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid     = 1'b0;
        ld_rsp_valid = 1'b0;
    endtask

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_SYS = 7'b1110011;

    initial begin
        logic [31:0] bad;
        rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; in_alures = '0;
        in_csrdata = '0; ld_rsp_valid = 1'b0; ld_rsp_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_wen", {63'd0, rd_wen}, 64'd0);
        chk("rst_idx", {59'd0, rd_idx}, 64'd0);
        chk("rst_data", rd_data, 64'd0);
        chk("rst_err", {63'd0, ld_rsp_err}, 64'd0);
`ifdef WB_TRACE_EN
        chk("rst_commit_valid", {63'd0, commit_valid}, 64'd0);
        chk("rst_instret", instret, 64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {63'd0, in_ready}, 64'd1);

        // add x5: latency 1, stays in IDLE
        issue(mk(OP_R, 3'b000, 5'd5), 64'h1234, 64'd0, 1'b0, 64'd0, 1'b1, 64'h1234, 1'b1);
        idle();
        chk("ready_after_add", {63'd0, in_ready}, 64'd1);

        // lb x6 at offset 3, response four cycles after acceptance
        issue(mk(OP_LD, 3'b000, 5'd6), 64'h1003, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0; in_instr = '0; in_alures = '0;
            chk("wait_ready", {63'd0, in_ready}, 64'd0);
            if (k == 3) begin
                ld_rsp_valid = 1'b1;
                ld_rsp_data  = 64'h0000_0000_8000_0000;
                q.push_back('{5'd6, 64'hFFFF_FFFF_FFFF_FF80, cyc + 1});
                ncommit++;
            end
        end
        idle();
        chk("ready_after_ld", {63'd0, in_ready}, 64'd1);

        // same-cycle loads of every width
        issue(mk(OP_LD, 3'b101, 5'd8),  64'h2000, 64'd0, 1'b1, 64'h0000_0000_0000_ABCD, 1'b1, 64'h0000_0000_0000_ABCD, 1'b1);
        issue(mk(OP_LD, 3'b010, 5'd12), 64'h2004, 64'd0, 1'b1, 64'hDEAD_BEEF_0000_0000, 1'b1, 64'hFFFF_FFFF_DEAD_BEEF, 1'b1);
        issue(mk(OP_LD, 3'b011, 5'd13), 64'h2000, 64'd0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1);
        issue(mk(OP_LD, 3'b100, 5'd14), 64'h2007, 64'd0, 1'b1, 64'hF000_0000_0000_0000, 1'b1, 64'h0000_0000_0000_00F0, 1'b1);
        issue(mk(OP_LD, 3'b001, 5'd15), 64'h2006, 64'd0, 1'b1, 64'h8001_0000_0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_8001, 1'b1);
        issue(mk(OP_LD, 3'b110, 5'd16), 64'h2004, 64'd0, 1'b1, 64'h89AB_CDEF_0000_0000, 1'b1, 64'h0000_0000_89AB_CDEF, 1'b1);
        issue(mk(OP_LD, 3'b010, 5'd0),  64'h2000, 64'd0, 1'b1, 64'h0000_0000_1111_1111, 1'b0, 64'd0, 1'b1);

        // csrrs x7 writes CSR data; ecall writes nothing
        issue(mk(OP_SYS, 3'b010, 5'd7), 64'h5555, 64'h8000_0000_0000_1800, 1'b0, 64'd0, 1'b1, 64'h8000_0000_0000_1800, 1'b1);
        issue(32'h0000_0073, 64'h5555, 64'h1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1);

        // sw, beq, addi x0, then back-to-back addi and a malformed encoding
        issue(mk(OP_ST, 3'b010, 5'd3), 64'h7777, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1);
        issue(mk(OP_BR, 3'b000, 5'd4), 64'h7777, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1);
        issue(mk(OP_I, 3'b000, 5'd0),  64'h7777, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1);
        issue(mk(OP_I, 3'b000, 5'd9),  64'h11,   64'd0, 1'b0, 64'd0, 1'b1, 64'h11, 1'b1);
        issue(mk(OP_I, 3'b000, 5'd10), 64'h22,   64'd0, 1'b0, 64'd0, 1'b1, 64'h22, 1'b1);
        bad = mk(OP_I, 3'b000, 5'd11);
        bad[1:0] = 2'b10;
        issue(bad, 64'h33, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b1);
        idle();
        chk("err_still_clear", {63'd0, ld_rsp_err}, 64'd0);
`ifdef WB_TRACE_EN
        chk("instret_count", instret, 64'(ncommit));
`endif

        // reset during WAIT_LD, response arrives afterwards
        issue(mk(OP_LD, 3'b000, 5'd6), 64'h1003, 64'd0, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0);
        idle();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ncommit = 0;
        @(negedge clk);
        chk("ready_after_rst2", {63'd0, in_ready}, 64'd1);
        chk("err_cleared", {63'd0, ld_rsp_err}, 64'd0);
        ld_rsp_valid = 1'b1;
        ld_rsp_data  = 64'h0000_0000_8000_0000;
        @(negedge clk);
        ld_rsp_valid = 1'b0;
        chk("stray_err", {63'd0, ld_rsp_err}, 64'd1);
        chk("stray_wen", {63'd0, rd_wen}, 64'd0);
        chk("stray_idx", {59'd0, rd_idx}, 64'd0);
        chk("stray_data", rd_data, 64'd0);
`ifdef WB_TRACE_EN
        chk("stray_commit_valid", {63'd0, commit_valid}, 64'd0);
        chk("stray_commit_pc", commit_pc, 64'd0);
        chk("stray_commit_instr", {32'd0, commit_instr}, 64'd0);
        chk("stray_instret", instret, 64'(ncommit));
`endif
        repeat (2) @(negedge clk);
        chk("err_sticky", {63'd0, ld_rsp_err}, 64'd1);
        chk("sb_drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
